// File: rtl/pipe_ctrl.sv
// Hazard, branch/jump and stage-control unit for a classic 5-stage MIPS-style pipeline.
// Decodes the ID instruction, tracks control bundles through ID/EX, EX/MEM and MEM/WB.
module pipe_ctrl #(
  parameter int XLEN   = 32,
  parameter int RA_W   = 5,
  parameter int FWD_EN = 1,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      inst_id,
  input  logic             id_valid,
  input  logic [XLEN-1:0]  pc_id,
  input  logic             ex_zero,
  output logic             stall,
  output logic             flush_ifid,
  output logic [1:0]       pc_sel,
  output logic [XLEN-1:0]  jump_target,
  output logic [6:0]       ex_ctrl,
  output logic [1:0]       m_ctrl,
  output logic [1:0]       wb_ctrl,
  output logic [RA_W-1:0]  wb_dst,
  output logic [CNT_W-1:0] bubble_cnt
);

  function automatic logic [CNT_W-1:0] satAdd(input logic [CNT_W-1:0] a, input logic [1:0] inc);
    logic [CNT_W:0] sum;
    sum = {1'b0, a} + {{(CNT_W-1){1'b0}}, inc};
    return sum[CNT_W] ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
  endfunction

  function automatic logic srcHit(input logic useSrc, input logic [RA_W-1:0] src,
                                  input logic [RA_W-1:0] dst, input logic regWr);
    return useSrc && regWr && (dst != '0) && (src == dst);
  endfunction

  logic [5:0]      opcode, funct;
  logic [RA_W-1:0] rsA, rtA, rdA;
  logic            dRegDst, dAluSrc, dMemRead, dMemWrite, dRegWrite, dMemToReg;
  logic [4:0]      dAluOp;
  logic            dBeq, dBne, dJump, dUseRs, dUseRt, dLive;
  logic [RA_W-1:0] dDst;

  logic            vld_p0, vld_p1, vld_p2;
  logic [6:0]      exCtrl_p0;
  logic [1:0]      mCtrl_p0, mCtrl_p1;
  logic [1:0]      wbCtrl_p0, wbCtrl_p1, wbCtrl_p2;
  logic [RA_W-1:0] dst_p0, dst_p1, dst_p2;
  logic            beq_p0, bne_p0;

  logic            hazP0, hazP1, stallRaw, taken, jumpGo, loadIdEx;
  logic [1:0]      bubbleInc;
  logic            unusedPcLow;

  assign opcode      = inst_id[31:26];
  assign funct       = inst_id[5:0];
  assign rsA         = RA_W'(inst_id[25:21]);
  assign rtA         = RA_W'(inst_id[20:16]);
  assign rdA         = RA_W'(inst_id[15:11]);
  assign unusedPcLow = ^pc_id[27:0];

  always_comb begin
    dRegDst   = 1'b0;
    dAluSrc   = 1'b0;
    dAluOp    = 5'b00000;
    dMemRead  = 1'b0;
    dMemWrite = 1'b0;
    dRegWrite = 1'b0;
    dMemToReg = 1'b0;
    dBeq      = 1'b0;
    dBne      = 1'b0;
    dJump     = 1'b0;
    dUseRs    = 1'b0;
    dUseRt    = 1'b0;
    dDst      = '0;
    dLive     = 1'b0;
    if (id_valid) begin
      case (opcode)
        6'b000000: begin
          dLive = 1'b1;
          case (funct)
            6'b100000: dAluOp = 5'b00001;
            6'b100010: dAluOp = 5'b00010;
            6'b100100: dAluOp = 5'b00100;
            6'b101010: dAluOp = 5'b01000;
            6'b100101: dAluOp = 5'b10000;
            default:   dLive  = 1'b0;
          endcase
          // An unrecognised funct stays a full bubble, including its ALU code.
          if (dLive) begin
            dRegDst   = 1'b1;
            dRegWrite = 1'b1;
            dDst      = rdA;
            dUseRs    = 1'b1;
            dUseRt    = 1'b1;
          end
        end
        6'b100011: begin
          dLive     = 1'b1;
          dAluSrc   = 1'b1;
          dAluOp    = 5'b00001;
          dMemRead  = 1'b1;
          dMemToReg = 1'b1;
          dRegWrite = 1'b1;
          dDst      = rtA;
          dUseRs    = 1'b1;
        end
        6'b101011: begin
          dLive     = 1'b1;
          dAluSrc   = 1'b1;
          dAluOp    = 5'b00001;
          dMemWrite = 1'b1;
          dUseRs    = 1'b1;
          dUseRt    = 1'b1;
        end
        6'b000100, 6'b000101: begin
          dLive  = 1'b1;
          dAluOp = 5'b00010;
          dBeq   = (opcode == 6'b000100);
          dBne   = (opcode == 6'b000101);
          dUseRs = 1'b1;
          dUseRt = 1'b1;
        end
        6'b000010: dJump = 1'b1;
        default: ;
      endcase
    end
  end

  assign hazP0 = vld_p0 && (srcHit(dUseRs, rsA, dst_p0, wbCtrl_p0[1]) ||
                            srcHit(dUseRt, rtA, dst_p0, wbCtrl_p0[1]));
  assign hazP1 = vld_p1 && (srcHit(dUseRs, rsA, dst_p1, wbCtrl_p1[1]) ||
                            srcHit(dUseRt, rtA, dst_p1, wbCtrl_p1[1]));

  // With forwarding only a load in EX cannot be bypassed; without it any producer in EX or MEM blocks.
  assign stallRaw = (FWD_EN != 0) ? (hazP0 && mCtrl_p0[1]) : (hazP0 || hazP1);

  assign taken       = vld_p0 && ((beq_p0 && ex_zero) || (bne_p0 && !ex_zero));
  assign jumpGo      = dJump && !taken && !stallRaw && !rst;
  assign stall       = stallRaw && !taken;
  assign flush_ifid  = taken || jumpGo;
  assign pc_sel      = taken ? 2'b10 : (jumpGo ? 2'b01 : 2'b00);
  assign jump_target = {pc_id[XLEN-1:28], inst_id[25:0], 2'b00};
  assign loadIdEx    = dLive && !taken && !stallRaw;
  assign bubbleInc   = taken ? 2'd2 : (stallRaw ? 2'd1 : 2'd0);

  assign ex_ctrl = exCtrl_p0;
  assign m_ctrl  = mCtrl_p1;
  assign wb_ctrl = wbCtrl_p2 & {2{vld_p2}};
  assign wb_dst  = dst_p2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p0     <= 1'b0;
      exCtrl_p0  <= '0;
      mCtrl_p0   <= '0;
      wbCtrl_p0  <= '0;
      dst_p0     <= '0;
      beq_p0     <= 1'b0;
      bne_p0     <= 1'b0;
      vld_p1     <= 1'b0;
      mCtrl_p1   <= '0;
      wbCtrl_p1  <= '0;
      dst_p1     <= '0;
      vld_p2     <= 1'b0;
      wbCtrl_p2  <= '0;
      dst_p2     <= '0;
      bubble_cnt <= '0;
    end else begin
      // ID -> ID/EX
      vld_p0     <= loadIdEx;
      exCtrl_p0  <= loadIdEx ? {dRegDst, dAluSrc, dAluOp} : 7'd0;
      mCtrl_p0   <= loadIdEx ? {dMemRead, dMemWrite} : 2'd0;
      wbCtrl_p0  <= loadIdEx ? {dRegWrite, dMemToReg} : 2'd0;
      dst_p0     <= loadIdEx ? dDst : '0;
      beq_p0     <= loadIdEx && dBeq;
      bne_p0     <= loadIdEx && dBne;
      // ID/EX -> EX/MEM
      vld_p1     <= vld_p0;
      mCtrl_p1   <= mCtrl_p0;
      wbCtrl_p1  <= wbCtrl_p0;
      dst_p1     <= dst_p0;
      // EX/MEM -> MEM/WB
      vld_p2     <= vld_p1;
      wbCtrl_p2  <= wbCtrl_p1;
      dst_p2     <= dst_p1;
      bubble_cnt <= satAdd(bubble_cnt, bubbleInc);
    end
  end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: vector table on a forwarding instance, plus hand sequences on a
// non-forwarding instance with a 2-bit bubble counter and an asynchronous reset check.
module tb_pipe_ctrl;

  typedef struct {
    logic [31:0] inst;
    logic        vld;
    logic        zero;
    logic        eStall;
    logic        eFlush;
    logic [1:0]  eSel;
    logic [15:0] eBnd;  // {ex[6:0], m[1:0], wb[1:0], dst[4:0]}
    logic [15:0] eCnt;
    logic [31:0] eJt;
  } vec_t;

  localparam logic [15:0] NOP  = 16'h0000;
  localparam logic [15:0] ADD3 = {7'b1000001, 2'b00, 2'b10, 5'd3};
  localparam logic [15:0] SUB4 = {7'b1000010, 2'b00, 2'b10, 5'd4};
  localparam logic [15:0] LW5  = {7'b0100001, 2'b10, 2'b11, 5'd5};
  localparam logic [15:0] ADD6 = {7'b1000001, 2'b00, 2'b10, 5'd6};
  localparam logic [15:0] AND7 = {7'b1000100, 2'b00, 2'b10, 5'd7};
  localparam logic [15:0] OR8  = {7'b1010000, 2'b00, 2'b10, 5'd8};
  localparam logic [15:0] SLT9 = {7'b1001000, 2'b00, 2'b10, 5'd9};
  localparam logic [15:0] SWB  = {7'b0100001, 2'b01, 2'b00, 5'd0};
  localparam logic [15:0] BRB  = {7'b0000010, 2'b00, 2'b00, 5'd0};
  localparam logic [15:0] LW0  = {7'b0100001, 2'b10, 2'b11, 5'd0};

  localparam logic [31:0] I_ADD3 = 32'h00221820;  // add r3,r1,r2
  localparam logic [31:0] I_SUB4 = 32'h00612022;  // sub r4,r3,r1
  localparam logic [31:0] I_LW5  = 32'h8C250000;  // lw r5,0(r1)
  localparam logic [31:0] I_ADD6 = 32'h00A23020;  // add r6,r5,r2
  localparam logic [31:0] I_AND7 = 32'h00223824;
  localparam logic [31:0] I_OR8  = 32'h00224025;
  localparam logic [31:0] I_SLT9 = 32'h0022482A;
  localparam logic [31:0] I_SW   = 32'hAC250004;  // sw r5,4(r1)
  localparam logic [31:0] I_J1   = 32'h08000100;  // j 0x100
  localparam logic [31:0] I_J2   = 32'h08A00000;  // j 0xA00000 (rs field = 5)
  localparam logic [31:0] I_BEQ  = 32'h10220004;
  localparam logic [31:0] I_BNE  = 32'h14220004;
  localparam logic [31:0] I_LW0  = 32'h8C200000;  // lw r0,0(r1)
  localparam logic [31:0] I_A6R0 = 32'h00023020;  // add r6,r0,r2
  localparam logic [31:0] I_BADO = 32'hFC221820;  // opcode 111111
  localparam logic [31:0] I_BADF = 32'h0022183F;  // R-type, unknown funct
  localparam logic [31:0] PCV    = 32'h40000008;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] inst, inst0;
  logic        idv, idv0, zr, zr0;
  logic [31:0] pc, pc0;
  logic        stall, flush;
  logic [1:0]  pcSel;
  logic [31:0] jt;
  logic [6:0]  exC;
  logic [1:0]  mC, wbC;
  logic [4:0]  wbD;
  logic [15:0] cnt;
  logic        stall0, flush0;
  logic [1:0]  pcSel0;
  logic [31:0] unusedJt0;
  logic [6:0]  exC0;
  logic [1:0]  unusedM0, unusedWb0;
  logic [4:0]  unusedWbd0;
  logic [1:0]  cnt0;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  pipe_ctrl #(.XLEN(32), .RA_W(5), .FWD_EN(1), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .inst_id(inst), .id_valid(idv), .pc_id(pc), .ex_zero(zr),
    .stall(stall), .flush_ifid(flush), .pc_sel(pcSel), .jump_target(jt),
    .ex_ctrl(exC), .m_ctrl(mC), .wb_ctrl(wbC), .wb_dst(wbD), .bubble_cnt(cnt)
  );

  pipe_ctrl #(.XLEN(32), .RA_W(5), .FWD_EN(0), .CNT_W(2)) dut0 (
    .clk(clk), .rst(rst), .inst_id(inst0), .id_valid(idv0), .pc_id(pc0), .ex_zero(zr0),
    .stall(stall0), .flush_ifid(flush0), .pc_sel(pcSel0), .jump_target(unusedJt0),
    .ex_ctrl(exC0), .m_ctrl(unusedM0), .wb_ctrl(unusedWb0), .wb_dst(unusedWbd0), .bubble_cnt(cnt0)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic vec_t mkv(input logic [31:0] in, input logic v, input logic z,
                               input logic st, input logic fl, input logic [1:0] sel,
                               input logic [15:0] b, input logic [15:0] c, input logic [31:0] j);
    vec_t r;
    r.inst = in; r.vld = v; r.zero = z; r.eStall = st; r.eFlush = fl;
    r.eSel = sel; r.eBnd = b; r.eCnt = c; r.eJt = j;
    return r;
  endfunction

  // One cycle on the non-forwarding instance: check combinational outputs, clock, check registered ones.
  task automatic s0(input string nm, input logic [31:0] in, input logic z, input logic eSt,
                    input logic eFl, input logic [1:0] eSel, input logic [1:0] eCnt,
                    input logic [6:0] eEx);
    inst0 = in; idv0 = (in != 32'h0); zr0 = z;
    #1;
    chk({nm, " stall"}, 32'(stall0), 32'(eSt));
    chk({nm, " flush"}, 32'(flush0), 32'(eFl));
    chk({nm, " pc_sel"}, 32'(pcSel0), 32'(eSel));
    @(posedge clk); #1;
    chk({nm, " bubble_cnt"}, 32'(cnt0), 32'(eCnt));
    chk({nm, " ex_ctrl"}, 32'(exC0), 32'(eEx));
    @(negedge clk);
  endtask

  vec_t        tbl[28];
  logic [15:0] sb[$];
  logic [15:0] top, mid, old;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; inst = I_J1; idv = 1'b1; pc = PCV; zr = 1'b0;
    inst0 = '0; idv0 = 1'b0; pc0 = PCV; zr0 = 1'b0;
    #3;
    chk("reset stall", 32'(stall), 32'd0);
    chk("reset flush", 32'(flush), 32'd0);
    chk("reset pc_sel", 32'(pcSel), 32'd0);
    chk("reset ex_ctrl", 32'(exC), 32'd0);
    chk("reset wb_ctrl", 32'(wbC), 32'd0);
    chk("reset bubble_cnt", 32'(cnt), 32'd0);

    tbl[0]  = mkv(I_ADD3, 1, 0, 0, 0, 2'd0, ADD3, 0, 0);
    tbl[1]  = mkv(I_SUB4, 1, 0, 0, 0, 2'd0, SUB4, 0, 0);
    tbl[2]  = mkv(I_LW5,  1, 0, 0, 0, 2'd0, LW5,  0, 0);
    tbl[3]  = mkv(I_ADD6, 1, 0, 1, 0, 2'd0, NOP,  1, 0);
    tbl[4]  = mkv(I_ADD6, 1, 0, 0, 0, 2'd0, ADD6, 1, 0);
    tbl[5]  = mkv(I_AND7, 1, 0, 0, 0, 2'd0, AND7, 1, 0);
    tbl[6]  = mkv(I_OR8,  1, 0, 0, 0, 2'd0, OR8,  1, 0);
    tbl[7]  = mkv(I_SLT9, 1, 0, 0, 0, 2'd0, SLT9, 1, 0);
    tbl[8]  = mkv(I_SW,   1, 0, 0, 0, 2'd0, SWB,  1, 0);
    tbl[9]  = mkv(I_J1,   1, 0, 0, 1, 2'd1, NOP,  1, 32'h40000400);
    tbl[10] = mkv(I_BEQ,  1, 0, 0, 0, 2'd0, BRB,  1, 0);
    tbl[11] = mkv(I_AND7, 1, 1, 0, 1, 2'd2, NOP,  3, 0);
    tbl[12] = mkv(I_BNE,  1, 0, 0, 0, 2'd0, BRB,  3, 0);
    tbl[13] = mkv(I_OR8,  1, 0, 0, 1, 2'd2, NOP,  5, 0);
    tbl[14] = mkv(I_BNE,  1, 0, 0, 0, 2'd0, BRB,  5, 0);
    tbl[15] = mkv(I_SLT9, 1, 1, 0, 0, 2'd0, SLT9, 5, 0);
    tbl[16] = mkv(I_LW0,  1, 0, 0, 0, 2'd0, LW0,  5, 0);
    tbl[17] = mkv(I_A6R0, 1, 0, 0, 0, 2'd0, ADD6, 5, 0);
    tbl[18] = mkv(I_BADO, 1, 0, 0, 0, 2'd0, NOP,  5, 0);
    tbl[19] = mkv(I_BADF, 1, 0, 0, 0, 2'd0, NOP,  5, 0);
    tbl[20] = mkv(I_ADD3, 0, 0, 0, 0, 2'd0, NOP,  5, 0);
    tbl[21] = mkv(I_BEQ,  1, 0, 0, 0, 2'd0, BRB,  5, 0);
    tbl[22] = mkv(I_J1,   1, 1, 0, 1, 2'd2, NOP,  7, 0);
    tbl[23] = mkv(I_LW5,  1, 0, 0, 0, 2'd0, LW5,  7, 0);
    tbl[24] = mkv(I_J2,   1, 0, 0, 1, 2'd1, NOP,  7, 32'h42800000);
    tbl[25] = mkv(32'h0,  0, 0, 0, 0, 2'd0, NOP,  7, 0);
    tbl[26] = mkv(32'h0,  0, 0, 0, 0, 2'd0, NOP,  7, 0);
    tbl[27] = mkv(32'h0,  0, 0, 0, 0, 2'd0, NOP,  7, 0);

    @(negedge clk);
    rst = 1'b0;
    sb.push_back(NOP);
    sb.push_back(NOP);

    for (int i = 0; i < 28; i++) begin
      inst = tbl[i].inst; idv = tbl[i].vld; zr = tbl[i].zero; pc = PCV;
      sb.push_back(tbl[i].eBnd);
      #1;
      chk($sformatf("r%0d stall", i), 32'(stall), 32'(tbl[i].eStall));
      chk($sformatf("r%0d flush", i), 32'(flush), 32'(tbl[i].eFlush));
      chk($sformatf("r%0d pc_sel", i), 32'(pcSel), 32'(tbl[i].eSel));
      if (tbl[i].eSel == 2'd1) chk($sformatf("r%0d jump_target", i), jt, tbl[i].eJt);
      @(posedge clk); #1;
      top = sb[2];
      mid = sb[1];
      old = sb.pop_front();
      chk($sformatf("r%0d ex_ctrl", i), 32'(exC), 32'(top[15:9]));
      chk($sformatf("r%0d m_ctrl", i), 32'(mC), 32'(mid[8:7]));
      chk($sformatf("r%0d wb_ctrl", i), 32'(wbC), 32'(old[6:5]));
      if (old[6]) chk($sformatf("r%0d wb_dst", i), 32'(wbD), 32'(old[4:0]));
      chk($sformatf("r%0d bubble_cnt", i), 32'(cnt), 32'(tbl[i].eCnt));
      @(negedge clk);
    end

    // Non-forwarding instance: 2-cycle load-use, branch over a stall, ALU RAW, counter saturation.
    s0("n1",  I_LW5,  0, 0, 0, 2'd0, 2'd0, 7'b0100001);
    s0("n2",  I_ADD6, 0, 1, 0, 2'd0, 2'd1, 7'b0000000);
    s0("n3",  I_ADD6, 0, 1, 0, 2'd0, 2'd2, 7'b0000000);
    s0("n4",  I_ADD6, 0, 0, 0, 2'd0, 2'd2, 7'b1000001);
    s0("n5",  I_LW5,  0, 0, 0, 2'd0, 2'd2, 7'b0100001);
    s0("n6",  I_BEQ,  0, 0, 0, 2'd0, 2'd2, 7'b0000010);
    s0("n7",  I_ADD6, 1, 0, 1, 2'd2, 2'd3, 7'b0000000);
    s0("n8",  32'h0,  0, 0, 0, 2'd0, 2'd3, 7'b0000000);
    s0("n9",  I_ADD3, 0, 0, 0, 2'd0, 2'd3, 7'b1000001);
    s0("n10", I_SUB4, 0, 1, 0, 2'd0, 2'd3, 7'b0000000);
    s0("n11", I_SUB4, 0, 1, 0, 2'd0, 2'd3, 7'b0000000);
    s0("n12", I_SUB4, 0, 0, 0, 2'd0, 2'd3, 7'b1000010);
    inst0 = '0; idv0 = 1'b0;

    // Asynchronous reset with a writer in MEM/WB and a load-use stall pending in ID.
    inst = I_ADD3; idv = 1'b1; zr = 1'b0;
    @(posedge clk); @(negedge clk);
    idv = 1'b0;
    @(posedge clk); @(negedge clk);
    inst = I_LW5; idv = 1'b1;
    @(posedge clk); @(negedge clk);
    inst = I_ADD6;
    #1;
    chk("pre-reset stall", 32'(stall), 32'd1);
    chk("pre-reset wb_ctrl", 32'(wbC), 32'b10);
    chk("pre-reset wb_dst", 32'(wbD), 32'd3);
    #1 rst = 1'b1;
    #1;
    chk("async wb_ctrl", 32'(wbC), 32'd0);
    chk("async wb_dst", 32'(wbD), 32'd0);
    chk("async ex_ctrl", 32'(exC), 32'd0);
    chk("async stall", 32'(stall), 32'd0);
    chk("async bubble_cnt", 32'(cnt), 32'd0);
    inst = I_J1;
    #1;
    chk("reset jump pc_sel", 32'(pcSel), 32'd0);
    chk("reset jump flush", 32'(flush), 32'd0);
    @(negedge clk);
    rst = 1'b0; inst = I_ADD6;
    #1;
    chk("post-reset stall", 32'(stall), 32'd0);
    @(posedge clk); #1;
    chk("post-reset ex_ctrl", 32'(exC), 32'b1000001);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 Parameter: XLEN, 32, PC and jump-target width.
REQ-002 Parameter: RA_W, 5, register-address width.
REQ-003 Parameter: FWD_EN, 1, 1 = forwarding datapath present (load-use stall only); 0 = no forwarding (stall on any in-flight RAW).
REQ-004 Parameter: CNT_W, 16, bubble-counter width.
REQ-005 Port: clk  in  1  single clock; all state updates on rising edge.
REQ-006 Port: rst  in  1  asynchronous, active-high reset.
REQ-007 Port: inst_id  in  32  instruction currently in ID.
REQ-008 Port: id_valid  in  1  inst_id holds a real instruction.
REQ-009 Port: pc_id  in  XLEN  PC+4 of the ID instruction.
REQ-010 Port: ex_zero  in  1  ALU zero flag of the instruction in EX.
REQ-011 Port: stall  out  1  hold PC and IF/ID register this cycle.
REQ-012 Port: flush_ifid  out  1  squash IF/ID register at next edge.
REQ-013 Port: pc_sel  out  2  00 = PC+4, 01 = jump_target, 10 = branch target (computed outside).
REQ-014 Port: jump_target  out  XLEN  {pc_id[XLEN-1:28], inst_id[25:0], 2'b00}.
REQ-015 Port: ex_ctrl  out  7  {RegDst, ALUsrc, ALUop[4:0]} from ID/EX stage.
REQ-016 Port: m_ctrl  out  2  {MemRead, MemWrite} from EX/MEM stage.
REQ-017 Port: wb_ctrl  out  2  {RegWrite, MemToReg} from MEM/WB stage; wb_dst out RA_W.
REQ-018 Port: bubble_cnt  out  CNT_W  count of bubbles inserted, saturating at all-ones.

Function
REQ-019 Decode (opcode inst[31:26]): R-type 000000 sets RegDst and RegWrite, with ALUop from funct: ADD 100000->00001, SUB 100010->00010, AND 100100->00100, SLT 101010->01000, OR 100101->10000.
REQ-020 LW 100011 sets ALUsrc, ALUop=00001, MemRead, MemToReg and RegWrite, with dst=rt; SW 101011 sets ALUsrc, ALUop=00001 and MemWrite.
REQ-021 BEQ 000100 and BNE 000101 set ALUop=00010 plus a type flag carried to EX; J 000010 is handled in ID only.
REQ-022 Unknown opcode, unknown funct, or id_valid=0 decodes as a bubble: all control bits 0, ALUop=00000.
REQ-023 Pipeline: ID/EX, EX/MEM and MEM/WB registers carry control bundle, dst, branch type and valid; each stage advances every cycle (no back-pressure past ID).
REQ-024 Sources: rs is used by all except J; rt is used by R-type, SW, BEQ and BNE; a hazard requires a source equal to a stage dst, with RegWrite=1 and dst!=0.
REQ-025 FWD_EN=1: stall=1 iff ID/EX holds an LW whose dst matches a used ID source, giving exactly 1 bubble.
REQ-026 FWD_EN=0: stall=1 iff a used source matches the ID/EX or EX/MEM dst; MEM/WB never stalls (write-first register file), so the maximum is 2 bubbles.
REQ-027 Stall: ID/EX loads a bubble, the ID instruction is held, pc_sel=00, and bubble_cnt increments.
REQ-028 Branch resolves in EX: taken = (BEQ & ex_zero) | (BNE & ~ex_zero); when taken, pc_sel=10, flush_ifid=1, ID/EX loads a bubble next edge, and bubble_cnt increments by 2 (saturating).
REQ-029 Jump in ID, when not stalled and no taken branch: pc_sel=01, flush_ifid=1, and the J enters ID/EX as a bubble.
REQ-030 Priority: taken branch > stall > jump; a taken branch overrides a concurrent stall or jump in ID, and stall=0 that cycle.
REQ-031 stall, flush_ifid, pc_sel and jump_target are combinational from the current ID and pipeline state; ex_ctrl, m_ctrl, wb_ctrl and wb_dst are registered outputs.

Reset
REQ-032 While rst=1, all pipeline valid and control bits, dst fields and bubble_cnt are 0 immediately (asynchronously), regardless of clk.
REQ-033 Outputs during reset: stall=0, flush_ifid=0, pc_sel=00; reset deasserted mid-stall resumes with empty pipeline and no stall.

Verification
REQ-034 ADD r3,r1,r2 then the next cycle SUB r4,r3,r1 with FWD_EN=1 -> no stall, ex_ctrl=1_0_00010 one cycle after ex_ctrl=1_0_00001.
REQ-035 LW r5,0(r1) then ADD r6,r5,r2 -> FWD_EN=1: 1 cycle stall=1, bubble_cnt=1; FWD_EN=0: 2 cycles stall=1, bubble_cnt=2.
REQ-036 BEQ with ex_zero=1 in EX while LW-dependent ADD stalls in ID -> pc_sel=10, flush_ifid=1, stall=0, ID/EX bubble next edge.
REQ-037 J 0x0000100 with pc_id=0x40000008 -> pc_sel=01, jump_target=0x40000400, flush_ifid=1, ex_ctrl=0 next cycle.
REQ-038 Hazard against dst=r0, and an unknown opcode 111111 -> no stall, all controls 0; rst asserted mid-pipeline -> wb_ctrl=00 without clk edge.
